// File: rtl/xgmii2gmii_pkg.sv
// Shared lane codes, GMII constants, state encoding and lane classes for the
// XGMII-to-GMII transmit converter.
package xgmii2gmii_pkg;

  localparam int IFG_MIN_DEFAULT = 12;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  localparam logic [7:0] GMII_PRE = 8'h55;
  localparam logic [7:0] GMII_SFD = 8'hD5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DROP = 2'd2,
    ST_IFG  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    LANE_DATA  = 3'd0,
    LANE_START = 3'd1,
    LANE_TERM  = 3'd2,
    LANE_ERROR = 3'd3,
    LANE_IDLE  = 3'd4
  } lane_class_t;

endpackage

// File: rtl/xgmii2gmii_lane_decode.sv
// Classifies one XGMII lane (byte + control flag) into data/start/terminate/
// error/idle; any unrecognised control character counts as idle.
module xgmii_lane_decode
  import xgmii2gmii_pkg::*;
(
  input  logic [7:0]  data,
  input  logic        ctrl,
  output lane_class_t lane_class
);

  always_comb begin
    lane_class = LANE_DATA;
    if (ctrl) begin
      case (data)
        XGMII_START: lane_class = LANE_START;
        XGMII_TERM:  lane_class = LANE_TERM;
        XGMII_ERROR: lane_class = LANE_ERROR;
        default:     lane_class = LANE_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/xgmii2gmii.sv
// Serialises 64-bit XGMII words from a FWFT FIFO onto an 8-bit GMII transmit
// port, one lane per clock, enforcing a minimum inter-frame gap.
module xgmii2gmii
  import xgmii2gmii_pkg::*;
#(
  parameter int IFG_MIN = IFG_MIN_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [71:0] dout,
  input  logic        empty,
  output logic        rd_en,
  output logic        gmii_txen,
  output logic [7:0]  gmii_txd,
  output logic        gmii_txer,
  output logic        underrun,
  output state_t      fsm_state
);

  localparam int GW = $clog2(IFG_MIN + 1);

  logic [71:0] word_q;
  logic        word_vld;
  logic [2:0]  lane_q;
  state_t      state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;

  // With the buffer empty the FIFO head is consumed directly, so a newly
  // arriving word costs no idle cycle.
  logic [71:0] cur_word;
  logic        cur_vld;
  logic [2:0]  cur_lane;
  logic [7:0]  cur_ctrl;
  logic [7:0]  lane_byte;
  logic        lane_ctrl;
  lane_class_t lane_class;

  assign cur_word  = word_vld ? word_q : dout;
  assign cur_vld   = word_vld | ~empty;
  assign cur_lane  = word_vld ? lane_q : 3'd0;
  assign cur_ctrl  = cur_word[71:64];
  assign lane_byte = cur_word[{cur_lane, 3'b000} +: 8];
  assign lane_ctrl = cur_ctrl[cur_lane];

  xgmii_lane_decode u_decode (
    .data       (lane_byte),
    .ctrl       (lane_ctrl),
    .lane_class (lane_class)
  );

  logic start_ok, gap_done, consume;
  logic nx_en, nx_er, nx_ur;
  logic [7:0] nx_d;

  assign start_ok = (lane_class == LANE_START) && (cur_lane[1:0] == 2'b00);
  assign gap_done = (gap_q >= GW'(IFG_MIN));

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    consume = 1'b0;
    nx_en   = 1'b0;
    nx_er   = 1'b0;
    nx_d    = 8'h00;
    nx_ur   = 1'b0;
    if (state_q == ST_IFG && !gap_done) gap_d = gap_q + 1'b1;
    case (state_q)
      ST_IDLE, ST_IFG: begin
        if (cur_vld) begin
          if (start_ok && (state_q == ST_IDLE || gap_done)) begin
            consume = 1'b1;
            nx_en   = 1'b1;
            nx_d    = GMII_PRE;
            state_d = ST_SEND;
          end else if (!start_ok) begin
            consume = 1'b1;
          end
        end
        if (state_q == ST_IFG && gap_done && state_d == ST_IFG) state_d = ST_IDLE;
      end
      ST_SEND: begin
        if (!cur_vld) begin
          nx_en   = 1'b1;
          nx_er   = 1'b1;
          nx_ur   = 1'b1;
          state_d = ST_DROP;
        end else begin
          consume = 1'b1;
          case (lane_class)
            LANE_DATA: begin
              nx_en = 1'b1;
              nx_d  = lane_byte;
            end
            LANE_ERROR: begin
              nx_en = 1'b1;
              nx_er = 1'b1;
              nx_d  = XGMII_ERROR;
            end
            LANE_TERM: begin
              state_d = ST_IFG;
              gap_d   = GW'(1);
            end
            default: begin
              nx_en   = 1'b1;
              nx_er   = 1'b1;
              nx_d    = lane_byte;
              state_d = ST_IFG;
              gap_d   = GW'(1);
            end
          endcase
        end
      end
      ST_DROP: begin
        if (cur_vld) begin
          consume = 1'b1;
          if (lane_class == LANE_TERM) begin
            state_d = ST_IFG;
            gap_d   = GW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_en     = sys_rst & ~empty & (~word_vld | (consume & (lane_q == 3'd7)));
  assign fsm_state = state_q;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      word_q    <= '0;
      word_vld  <= 1'b0;
      lane_q    <= 3'd0;
      state_q   <= ST_IDLE;
      gap_q     <= GW'(IFG_MIN);
      gmii_txen <= 1'b0;
      gmii_txer <= 1'b0;
      gmii_txd  <= 8'h00;
      underrun  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      gmii_txen <= nx_en;
      gmii_txer <= nx_er;
      gmii_txd  <= nx_d;
      underrun  <= nx_ur;
      if (!word_vld) begin
        if (!empty) begin
          word_q   <= dout;
          word_vld <= 1'b1;
          lane_q   <= consume ? 3'd1 : 3'd0;
        end
      end else if (consume) begin
        if (lane_q == 3'd7) begin
          lane_q <= 3'd0;
          if (!empty) word_q <= dout;
          else        word_vld <= 1'b0;
        end else begin
          lane_q <= lane_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xgmii2gmii.sv
// Bench for xgmii2gmii: FIFO model feeding lane streams, GMII log, and a
// frame-level reference built from the lane stream.
module tb_xgmii2gmii;
  import xgmii2gmii_pkg::*;

  localparam int IFG = 12;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [71:0] dout;
  logic        empty;
  logic        rd_en, gmii_txen, gmii_txer, underrun;
  logic [7:0]  gmii_txd;
  state_t      fsm_state;

  int checks = 0;
  int passed = 0;

  always #5 sys_clk = ~sys_clk;

  xgmii2gmii #(.IFG_MIN(IFG)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .dout      (dout),
    .empty     (empty),
    .rd_en     (rd_en),
    .gmii_txen (gmii_txen),
    .gmii_txd  (gmii_txd),
    .gmii_txer (gmii_txer),
    .underrun  (underrun),
    .fsm_state (fsm_state)
  );

  // FIFO model: pops on the edge after rd_en was seen high, refreshed at +1
  logic [71:0] fifo_q[$];
  logic        pop_pending = 1'b0;
  int          rd_while_empty = 0;

  logic        logging = 1'b0;
  logic        en_q[$];
  logic [8:0]  dat_q[$];
  int          ur_cnt = 0;

  initial begin
    dout  = '0;
    empty = 1'b1;
  end

  always @(posedge sys_clk) begin
    #1;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    empty = (fifo_q.size() == 0);
    dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  always @(negedge sys_clk) begin
    pop_pending = rd_en;
    if (rd_en && empty) rd_while_empty++;
    if (logging) begin
      en_q.push_back(gmii_txen);
      dat_q.push_back({gmii_txer, gmii_txd});
      if (underrun) ur_cnt++;
    end
  end

  // reference stream: lanes {ctrl,byte}; expected bytes {dont_care,txer,txd}
  logic [8:0]  lanes[$];
  logic [9:0]  exp_q[$];
  int          exp_len[$];
  int          exp_gap[$];
  logic [71:0] words[$];
  int          term_idx, first_start, exp_ur;

  task automatic new_stream();
    lanes.delete(); exp_q.delete(); exp_len.delete(); exp_gap.delete(); words.delete();
    term_idx = -1; first_start = -1; exp_ur = 0;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) lanes.push_back({1'b1, XGMII_IDLE});
  endtask

  task automatic add_frame(input int len, input int err_pos);
    int s;
    logic [7:0] b;
    while (lanes.size() % 4 != 0) lanes.push_back({1'b1, XGMII_IDLE});
    s = lanes.size();
    if (first_start < 0) first_start = s;
    if (term_idx >= 0) exp_gap.push_back((s - term_idx) > IFG ? (s - term_idx) : IFG);
    lanes.push_back({1'b1, XGMII_START});
    exp_q.push_back({2'b00, GMII_PRE});
    for (int i = 0; i < 6; i++) begin
      lanes.push_back({1'b0, GMII_PRE});
      exp_q.push_back({2'b00, GMII_PRE});
    end
    lanes.push_back({1'b0, GMII_SFD});
    exp_q.push_back({2'b00, GMII_SFD});
    for (int i = 0; i < len; i++) begin
      if (i == err_pos) begin
        lanes.push_back({1'b1, XGMII_ERROR});
        exp_q.push_back({2'b01, XGMII_ERROR});
      end else begin
        b = 8'($urandom_range(0, 255));
        lanes.push_back({1'b0, b});
        exp_q.push_back({2'b00, b});
      end
    end
    term_idx = lanes.size();
    lanes.push_back({1'b1, XGMII_TERM});
    exp_len.push_back(8 + len);
  endtask

  task automatic pack_words();
    logic [71:0] w;
    while (lanes.size() % 8 != 0) lanes.push_back({1'b1, XGMII_IDLE});
    words.delete();
    for (int b = 0; b < lanes.size(); b += 8) begin
      w = '0;
      for (int l = 0; l < 8; l++) begin
        w[8*l +: 8] = lanes[b+l][7:0];
        w[64+l]     = lanes[b+l][8];
      end
      words.push_back(w);
    end
  endtask

  task automatic push_words(input int n);
    @(posedge sys_clk);
    #2;
    for (int i = 0; i < n && words.size() > 0; i++) fifo_q.push_back(words.pop_front());
  endtask

  task automatic clear_logs();
    en_q.delete(); dat_q.delete(); ur_cnt = 0;
  endtask

  task automatic drain(input string name, input int budget);
    repeat (budget) @(negedge sys_clk);
    logging = 1'b0;
    checks++;
    if (fifo_q.size() != 0 || fsm_state != ST_IDLE || gmii_txen !== 1'b0) begin
      $display("FAIL %s drain: fifo_left=%0d state=%0d txen=%b required 0/IDLE/0",
               name, fifo_q.size(), fsm_state, gmii_txen);
    end else passed++;
  endtask

  task automatic analyze(input string name);
    int i, f, pos, start, len, last_end, bad, n, lim, bad_k;
    logic [9:0] e, bad_e;
    logic [8:0] got, bad_got;
    i = 0; f = 0; pos = 0; last_end = 0; n = en_q.size();
    while (i < n) begin
      if (en_q[i] !== 1'b1) begin
        i++;
        continue;
      end
      start = i;
      while (i < n && en_q[i] === 1'b1) i++;
      len = i - start;
      if (f < exp_len.size()) begin
        if (f == 0) begin
          checks++;
          if (start != first_start + 2)
            $display("FAIL %s lead: first txen at sample %0d required %0d", name, start, first_start + 2);
          else passed++;
        end
        checks++;
        if (len != exp_len[f])
          $display("FAIL %s frame%0d length: got %0d required %0d", name, f, len, exp_len[f]);
        else passed++;
        lim = (len < exp_len[f]) ? len : exp_len[f];
        bad = 0; bad_k = 0; bad_e = '0; bad_got = '0;
        for (int k = 0; k < lim; k++) begin
          e   = exp_q[pos+k];
          got = dat_q[start+k];
          if (e[9] ? (got[8] !== e[8]) : (got !== e[8:0])) begin
            if (bad == 0) begin bad_k = k; bad_e = e; bad_got = got; end
            bad++;
          end
        end
        checks++;
        if (bad != 0)
          $display("FAIL %s frame%0d bytes: %0d wrong, first at %0d got txer/txd=%b/%h required %b/%h",
                   name, f, bad, bad_k, bad_got[8], bad_got[7:0], bad_e[8], bad_e[7:0]);
        else passed++;
        if (f > 0 && exp_gap[f-1] >= 0) begin
          checks++;
          if (start - last_end != exp_gap[f-1])
            $display("FAIL %s gap%0d: txen low %0d cycles required %0d", name, f, start - last_end, exp_gap[f-1]);
          else passed++;
        end
        pos += exp_len[f];
      end
      last_end = i;
      f++;
    end
    checks++;
    if (f != exp_len.size()) $display("FAIL %s frame_count: got %0d required %0d", name, f, exp_len.size());
    else passed++;
    checks++;
    if (ur_cnt != exp_ur) $display("FAIL %s underrun_pulses: got %0d required %0d", name, ur_cnt, exp_ur);
    else passed++;
  endtask

  task automatic run_stream(input string name);
    int budget;
    pack_words();
    budget = lanes.size() + 16 * exp_len.size() + 40;
    clear_logs();
    push_words(words.size());
    logging = 1'b1;
    drain(name, budget);
    analyze(name);
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    #3;
    checks++;
    if ({gmii_txen, gmii_txer, gmii_txd, rd_en, underrun} !== 12'h000 || fsm_state !== ST_IDLE)
      $display("FAIL reset_outputs: txen=%b txer=%b txd=%h rd_en=%b underrun=%b state=%0d required all 0/IDLE",
               gmii_txen, gmii_txer, gmii_txd, rd_en, underrun, fsm_state);
    else passed++;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_frame64();
    new_stream();
    add_frame(64, -1);
    add_idle(8);
    run_stream("frame64");
  endtask

  task automatic test_lane4_start();
    new_stream();
    add_idle(4);
    add_frame(50, -1);
    add_idle(8);
    run_stream("lane4_start");
  endtask

  task automatic test_back_to_back();
    new_stream();
    add_frame(60, -1);
    add_idle(3);
    add_frame(48, -1);
    add_idle(8);
    run_stream("back_to_back");
  endtask

  task automatic test_error_lane();
    new_stream();
    add_frame(40, 10);
    add_idle(8);
    run_stream("error_lane");
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      new_stream();
      add_idle($urandom_range(0, 7));
      for (int fr = 0; fr < 3; fr++) begin
        add_frame($urandom_range(40, 90), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 39) : -1);
        add_idle($urandom_range(0, 20));
      end
      run_stream("random");
    end
  endtask

  task automatic test_underrun();
    int waited;
    new_stream();
    add_frame(64, -1);
    while (exp_q.size() > 32) void'(exp_q.pop_back());
    exp_q.push_back({2'b11, 8'h00});
    exp_len[0] = 33;
    add_idle(5);
    add_frame(46, -1);
    exp_gap[0] = -1;
    add_idle(8);
    exp_ur = 1;
    pack_words();
    clear_logs();
    push_words(4);
    logging = 1'b1;
    waited = 0;
    while (fifo_q.size() != 0 && waited < 200) begin
      @(negedge sys_clk);
      waited++;
    end
    checks++;
    if (fifo_q.size() != 0) $display("FAIL underrun fifo_drain: %0d words left required 0", fifo_q.size());
    else passed++;
    repeat (20) @(negedge sys_clk);
    push_words(words.size());
    drain("underrun", lanes.size() + 80);
    analyze("underrun");
  endtask

  task automatic test_reset_mid_frame();
    logic seen;
    new_stream();
    add_frame(80, -1);
    pack_words();
    clear_logs();
    push_words(words.size());
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge sys_clk);
      if (gmii_txen === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL reset_mid txen_start: got %b required 1", seen);
    else passed++;
    repeat (5) @(negedge sys_clk);
    #2;
    sys_rst = 1'b0;
    #1;
    checks++;
    if ({gmii_txen, gmii_txer, gmii_txd, rd_en, underrun} !== 12'h000 || fsm_state !== ST_IDLE)
      $display("FAIL reset_mid outputs: txen=%b txer=%b txd=%h rd_en=%b underrun=%b state=%0d required all 0/IDLE",
               gmii_txen, gmii_txer, gmii_txd, rd_en, underrun, fsm_state);
    else passed++;
    fifo_q.delete();
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    new_stream();
    add_frame(46, 20);
    add_idle(8);
    run_stream("post_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame64();
    test_lane4_start();
    test_back_to_back();
    test_error_lane();
    test_random();
    test_underrun();
    test_reset_mid_frame();
    checks++;
    if (rd_while_empty != 0) $display("FAIL rd_en_while_empty: got %0d cycles required 0", rd_while_empty);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
